// File: rtl/spi_cmd_queue.sv
// spi_cmd_queue: buffers SPI commands, sequences them one at a time into an
// SPI controller, and queues the responses back in command order.
//
// Ports
//   clk, rst            : system clock, synchronous active-high reset
//   cmd_*               : command push interface (valid/ready), mode/len/cs/data
//   rsp_*               : response pop interface (valid/ready), data + error flag
//   spi_scom            : one-cycle start pulse to the SPI controller
//   spi_cpol/cpha/...   : transaction setup, held from SETUP until the next SETUP
//   spi_busy, spi_rx    : controller status and received bytes
//   cmd_level/rsp_level : FIFO occupancies
//   txn_count           : completed transactions (wraps)
module spi_cmd_queue #(
    parameter int unsigned DEPTH        = 4,
    parameter int unsigned BUSY_TIMEOUT = 7
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [1:0]  cmd_mode,
    input  logic [1:0]  cmd_len,
    input  logic [7:0]  cmd_cs,
    input  logic [31:0] cmd_data,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_data,
    output logic        rsp_err,
    output logic        spi_scom,
    output logic        spi_cpol,
    output logic        spi_cpha,
    output logic [1:0]  spi_data_len,
    output logic [7:0]  spi_cs,
    output logic [31:0] spi_tx,
    input  logic        spi_busy,
    input  logic [31:0] spi_rx,
    output logic [4:0]  cmd_level,
    output logic [4:0]  rsp_level,
    output logic [15:0] txn_count
);

    localparam int unsigned PtrW        = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [4:0]  DepthLvl    = 5'(DEPTH);
    // Last count value spent waiting for busy; a zero timeout behaves like one.
    localparam logic [15:0] TimeoutLast = (BUSY_TIMEOUT > 0) ? 16'(BUSY_TIMEOUT - 1) : 16'd0;
    localparam int unsigned CmdW        = 44;
    localparam int unsigned RspW        = 33;

    typedef enum logic [2:0] {
        StIdle,
        StSetup,
        StLaunch,
        StWaitBusy,
        StWaitDone,
        StCapture
    } state_e;

    // ------------------------------------------------------------------
    // Command FIFO: entry = {mode[1:0], len[1:0], cs[7:0], data[31:0]}
    // ------------------------------------------------------------------
    logic [CmdW-1:0] cmd_mem_q [DEPTH];
    logic [CmdW-1:0] cmd_mem_d [DEPTH];
    logic [PtrW-1:0] cmd_wr_q, cmd_wr_d;
    logic [PtrW-1:0] cmd_rd_q, cmd_rd_d;
    logic [4:0]      cmd_level_q, cmd_level_d;
    logic            cmd_push, cmd_pop;
    logic [CmdW-1:0] cmd_head;

    // ------------------------------------------------------------------
    // Response FIFO: entry = {err, data[31:0]}
    // ------------------------------------------------------------------
    logic [RspW-1:0] rsp_mem_q [DEPTH];
    logic [RspW-1:0] rsp_mem_d [DEPTH];
    logic [PtrW-1:0] rsp_wr_q, rsp_wr_d;
    logic [PtrW-1:0] rsp_rd_q, rsp_rd_d;
    logic [4:0]      rsp_level_q, rsp_level_d;
    logic            rsp_push, rsp_pop;
    logic [RspW-1:0] rsp_wdata;
    logic [RspW-1:0] rsp_head;

    // ------------------------------------------------------------------
    // Sequencer state and SPI-side registers
    // ------------------------------------------------------------------
    state_e      state_q, state_d;
    logic [15:0] cnt_q, cnt_d;
    logic        err_q, err_d;
    logic        cpol_q, cpol_d;
    logic        cpha_q, cpha_d;
    logic [1:0]  len_q, len_d;
    logic [7:0]  cs_q, cs_d;
    logic [31:0] tx_q, tx_d;
    logic [15:0] txn_q, txn_d;
    logic        inflight;
    logic        dispatch_ok;
    logic [31:0] rx_masked;

    assign cmd_ready = (cmd_level_q != DepthLvl);
    assign cmd_push  = cmd_valid && cmd_ready;
    assign cmd_head  = cmd_mem_q[cmd_rd_q];

    assign rsp_valid = (rsp_level_q != 5'd0);
    assign rsp_pop   = rsp_valid && rsp_ready;
    assign rsp_head  = rsp_mem_q[rsp_rd_q];
    // Storage is not reset, so the head is masked while the FIFO is empty.
    assign rsp_data  = rsp_valid ? rsp_head[31:0] : 32'h0;
    assign rsp_err   = rsp_valid && rsp_head[32];

    // The sequencer handles one transaction at a time, so at most one response
    // slot is ever reserved beyond those already occupied.
    assign inflight    = (state_q != StIdle);
    assign dispatch_ok = (cmd_level_q != 5'd0) &&
                         ((rsp_level_q + {4'd0, inflight}) < DepthLvl);

    // ------------------------------------------------------------------
    // Command FIFO next state
    // ------------------------------------------------------------------
    always_comb begin
        cmd_mem_d   = cmd_mem_q;
        cmd_wr_d    = cmd_wr_q;
        cmd_rd_d    = cmd_rd_q;
        cmd_level_d = cmd_level_q;
        if (cmd_push) begin
            cmd_mem_d[cmd_wr_q] = {cmd_mode, cmd_len, cmd_cs, cmd_data};
            cmd_wr_d            = cmd_wr_q + PtrW'(1);
        end
        if (cmd_pop) begin
            cmd_rd_d = cmd_rd_q + PtrW'(1);
        end
        case ({cmd_push, cmd_pop})
            2'b10:   cmd_level_d = cmd_level_q + 5'd1;
            2'b01:   cmd_level_d = cmd_level_q - 5'd1;
            default: cmd_level_d = cmd_level_q;
        endcase
    end

    // ------------------------------------------------------------------
    // Response FIFO next state
    // ------------------------------------------------------------------
    always_comb begin
        rsp_mem_d   = rsp_mem_q;
        rsp_wr_d    = rsp_wr_q;
        rsp_rd_d    = rsp_rd_q;
        rsp_level_d = rsp_level_q;
        if (rsp_push) begin
            rsp_mem_d[rsp_wr_q] = rsp_wdata;
            rsp_wr_d            = rsp_wr_q + PtrW'(1);
        end
        if (rsp_pop) begin
            rsp_rd_d = rsp_rd_q + PtrW'(1);
        end
        case ({rsp_push, rsp_pop})
            2'b10:   rsp_level_d = rsp_level_q + 5'd1;
            2'b01:   rsp_level_d = rsp_level_q - 5'd1;
            default: rsp_level_d = rsp_level_q;
        endcase
    end

    // Keep only the bytes actually clocked in; the rest of spi_rx is stale.
    always_comb begin
        rx_masked = 32'h0;
        case (len_q)
            2'd0:    rx_masked = {24'h0, spi_rx[7:0]};
            2'd1:    rx_masked = {16'h0, spi_rx[15:0]};
            2'd2:    rx_masked = {8'h0, spi_rx[23:0]};
            default: rx_masked = spi_rx;
        endcase
    end

    // ------------------------------------------------------------------
    // Sequencer next state
    // ------------------------------------------------------------------
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        err_d     = err_q;
        cpol_d    = cpol_q;
        cpha_d    = cpha_q;
        len_d     = len_q;
        cs_d      = cs_q;
        tx_d      = tx_q;
        txn_d     = txn_q;
        cmd_pop   = 1'b0;
        rsp_push  = 1'b0;
        rsp_wdata = '0;

        case (state_q)
            StIdle: begin
                // The head is popped on the edge into SETUP so the SPI setup
                // lines are already stable for the whole SETUP cycle.
                if (dispatch_ok) begin
                    cmd_pop = 1'b1;
                    cpol_d  = cmd_head[43];
                    cpha_d  = cmd_head[42];
                    len_d   = cmd_head[41:40];
                    cs_d    = cmd_head[39:32];
                    tx_d    = cmd_head[31:0];
                    state_d = StSetup;
                end
            end
            StSetup: begin
                state_d = StLaunch;
            end
            StLaunch: begin
                cnt_d   = 16'd0;
                err_d   = 1'b0;
                state_d = StWaitBusy;
            end
            StWaitBusy: begin
                if (spi_busy) begin
                    state_d = StWaitDone;
                end else if (cnt_q == TimeoutLast) begin
                    err_d   = 1'b1;
                    state_d = StCapture;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            StWaitDone: begin
                if (!spi_busy) begin
                    state_d = StCapture;
                end
            end
            StCapture: begin
                // A slot was reserved at dispatch, so this push always fits.
                rsp_push  = 1'b1;
                rsp_wdata = err_q ? {1'b1, 32'h0} : {1'b0, rx_masked};
                txn_d     = txn_q + 16'd1;
                state_d   = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StIdle;
            cnt_q       <= 16'd0;
            err_q       <= 1'b0;
            cpol_q      <= 1'b0;
            cpha_q      <= 1'b0;
            len_q       <= 2'd0;
            cs_q        <= 8'hFF;
            tx_q        <= 32'h0;
            txn_q       <= 16'd0;
            cmd_wr_q    <= '0;
            cmd_rd_q    <= '0;
            cmd_level_q <= 5'd0;
            rsp_wr_q    <= '0;
            rsp_rd_q    <= '0;
            rsp_level_q <= 5'd0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            err_q       <= err_d;
            cpol_q      <= cpol_d;
            cpha_q      <= cpha_d;
            len_q       <= len_d;
            cs_q        <= cs_d;
            tx_q        <= tx_d;
            txn_q       <= txn_d;
            cmd_wr_q    <= cmd_wr_d;
            cmd_rd_q    <= cmd_rd_d;
            cmd_level_q <= cmd_level_d;
            rsp_wr_q    <= rsp_wr_d;
            rsp_rd_q    <= rsp_rd_d;
            rsp_level_q <= rsp_level_d;
        end
    end

    // FIFO storage needs no reset; occupancy is tracked by the pointers.
    always_ff @(posedge clk) begin
        cmd_mem_q <= cmd_mem_d;
        rsp_mem_q <= rsp_mem_d;
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    // Gated by rst so a reset landing in LAUNCH never leaks a start pulse.
    assign spi_scom     = (state_q == StLaunch) && !rst;
    assign spi_cpol     = cpol_q;
    assign spi_cpha     = cpha_q;
    assign spi_data_len = len_q;
    assign spi_cs       = cs_q;
    assign spi_tx       = tx_q;
    assign cmd_level    = cmd_level_q;
    assign rsp_level    = rsp_level_q;
    assign txn_count    = txn_q;

endmodule

// File: tb/tb_spi_cmd_queue.sv
// Scoreboard bench for spi_cmd_queue with a loopback SPI device model.
module tb_spi_cmd_queue;

    localparam int Depth   = 4;
    localparam int Timeout = 7;

    logic        clk = 1'b0;
    logic        rst;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [1:0]  cmd_mode;
    logic [1:0]  cmd_len;
    logic [7:0]  cmd_cs;
    logic [31:0] cmd_data;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_data;
    logic        rsp_err;
    logic        spi_scom;
    logic        spi_cpol;
    logic        spi_cpha;
    logic [1:0]  spi_data_len;
    logic [7:0]  spi_cs;
    logic [31:0] spi_tx;
    logic        spi_busy;
    logic [31:0] spi_rx;
    logic [4:0]  cmd_level;
    logic [4:0]  rsp_level;
    logic [15:0] txn_count;

    spi_cmd_queue #(
        .DEPTH       (Depth),
        .BUSY_TIMEOUT(Timeout)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .cmd_valid   (cmd_valid),
        .cmd_ready   (cmd_ready),
        .cmd_mode    (cmd_mode),
        .cmd_len     (cmd_len),
        .cmd_cs      (cmd_cs),
        .cmd_data    (cmd_data),
        .rsp_valid   (rsp_valid),
        .rsp_ready   (rsp_ready),
        .rsp_data    (rsp_data),
        .rsp_err     (rsp_err),
        .spi_scom    (spi_scom),
        .spi_cpol    (spi_cpol),
        .spi_cpha    (spi_cpha),
        .spi_data_len(spi_data_len),
        .spi_cs      (spi_cs),
        .spi_tx      (spi_tx),
        .spi_busy    (spi_busy),
        .spi_rx      (spi_rx),
        .cmd_level   (cmd_level),
        .rsp_level   (rsp_level),
        .txn_count   (txn_count)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // Commands are packed {mode, len, cs, data}; responses {err, data}.
    logic [43:0] exp_disp_q[$];
    logic [32:0] exp_rsp_q[$];
    int          accepted   = 0;
    int          rsp_count  = 0;
    int          scom_count = 0;
    bit          hold_long  = 1'b0;

    logic [43:0] cfg_now;
    assign cfg_now = {spi_cpol, spi_cpha, spi_data_len, spi_cs, spi_tx};

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic fail(input string name);
        checks++;
        failures++;
        $display("FAIL %s: bound expired or unexpected event", name);
    endtask

    // Reference: a selected device returns the bytes it was sent, right
    // aligned; chip-select 0 selects nothing, so the transaction times out.
    function automatic logic [32:0] ref_rsp(input logic [43:0] c);
        int nb;
        nb = int'(c[41:40]) + 1;
        if (c[39:32] == 8'h00) return {1'b1, 32'h0};
        return {1'b0, c[31:0] >> (32 - 8 * nb)};
    endfunction

    // Device model rx: loopback bytes with random junk above them.
    function automatic logic [31:0] model_rx(input logic [43:0] c, input logic [31:0] junk);
        logic [63:0] w;
        int nb;
        nb = int'(c[41:40]) + 1;
        w  = (64'(c[31:0]) >> (32 - 8 * nb)) | (64'(junk) << (8 * nb));
        return w[31:0];
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // ------------------------------------------------------------------
    // Monitor: records accepted commands and scores popped responses.
    // ------------------------------------------------------------------
    logic [43:0] mon_cmd;
    logic [32:0] mon_exp;
    always @(negedge clk) begin
        if (!rst) begin
            if (cmd_valid && cmd_ready) begin
                mon_cmd = {cmd_mode, cmd_len, cmd_cs, cmd_data};
                exp_disp_q.push_back(mon_cmd);
                exp_rsp_q.push_back(ref_rsp(mon_cmd));
                accepted++;
            end
            if (rsp_valid && rsp_ready) begin
                rsp_count++;
                if (exp_rsp_q.size() == 0) begin
                    fail("rsp_unexpected");
                end else begin
                    mon_exp = exp_rsp_q.pop_front();
                    check("rsp", 64'({rsp_err, rsp_data}), 64'(mon_exp));
                end
            end
            check("level_bound", 64'(cmd_level > 5'(Depth) || rsp_level > 5'(Depth)), 64'(0));
            check("cmd_ready_full", 64'(cmd_ready), 64'(cmd_level != 5'(Depth)));
            check("rsp_valid_empty", 64'(rsp_valid), 64'(rsp_level != 5'd0));
        end
    end

    // ------------------------------------------------------------------
    // SPI device model and setup-line stability checks.
    // ------------------------------------------------------------------
    logic [43:0] prev_cfg;
    logic [43:0] cur_cfg;
    logic [43:0] want_cfg;
    int          m_delay;
    int          m_hold;
    initial begin : spi_model
        spi_busy = 1'b0;
        spi_rx   = 32'h0;
        prev_cfg = '0;
        forever begin
            @(posedge clk);
            #2;
            if (!rst && spi_scom) begin
                cur_cfg = cfg_now;
                scom_count++;
                if (exp_disp_q.size() == 0) begin
                    fail("dispatch_unexpected");
                end else begin
                    want_cfg = exp_disp_q.pop_front();
                    check("dispatch_cfg", 64'(cur_cfg), 64'(want_cfg));
                end
                check("cfg_settled", 64'(prev_cfg), 64'(cur_cfg));
                @(posedge clk);
                #2;
                if (!rst) check("scom_pulse", 64'(spi_scom), 64'(0));
                if (!rst && cur_cfg[39:32] != 8'h00) begin
                    m_delay = int'($urandom_range(0, 3));
                    for (int i = 0; i < m_delay && !rst; i++) begin
                        @(posedge clk);
                        #2;
                    end
                    if (!rst) begin
                        spi_rx   = model_rx(cur_cfg, $urandom);
                        spi_busy = 1'b1;
                        m_hold   = hold_long ? 30 : int'($urandom_range(1, 5));
                        for (int i = 0; i < m_hold && !rst; i++) begin
                            @(posedge clk);
                            #2;
                            if (!rst) check("cfg_held", 64'(cfg_now), 64'(cur_cfg));
                        end
                        spi_busy = 1'b0;
                        if (!rst) begin
                            @(posedge clk);
                            #2;
                            if (!rst) check("cfg_held_fall", 64'(cfg_now), 64'(cur_cfg));
                        end
                    end
                    spi_busy = 1'b0;
                end
            end
            prev_cfg = cfg_now;
        end
    end

    // ------------------------------------------------------------------
    // Stimulus helpers
    // ------------------------------------------------------------------
    task automatic push_cmd(input logic [1:0] mode, input logic [1:0] len,
                            input logic [7:0] cs, input logic [31:0] data);
        bit acc;
        int n;
        cmd_mode  = mode;
        cmd_len   = len;
        cmd_cs    = cs;
        cmd_data  = data;
        cmd_valid = 1'b1;
        n = 0;
        do begin
            acc = cmd_ready;
            tick();
            n++;
        end while (!acc && n < 400);
        cmd_valid = 1'b0;
        if (!acc) fail("push_timeout");
    endtask

    task automatic wait_scom(output int n);
        n = 0;
        while (!spi_scom && n < 60) begin
            tick();
            n++;
        end
        if (!spi_scom) fail("scom_timeout");
    endtask

    task automatic wait_drain();
        int n;
        n = 0;
        while ((exp_rsp_q.size() != 0 || cmd_level != 5'd0) && n < 800) begin
            tick();
            n++;
        end
        if (exp_rsp_q.size() != 0) fail("drain_timeout");
        repeat (2) tick();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        exp_disp_q.delete();
        exp_rsp_q.delete();
        accepted = 0;
        tick();
        tick();
        rst = 1'b0;
    endtask

    initial begin : watchdog
        #3_000_000;
        $display("FAIL watchdog: run did not complete");
        $fatal(1, "watchdog expired");
    end

    // ------------------------------------------------------------------
    // Main sequence
    // ------------------------------------------------------------------
    int n;
    int base;
    int rcount;
    initial begin
        rst       = 1'b1;
        cmd_valid = 1'b0;
        cmd_mode  = 2'd0;
        cmd_len   = 2'd0;
        cmd_cs    = 8'h0;
        cmd_data  = 32'h0;
        rsp_ready = 1'b1;
        tick();
        do_reset();

        // Reset state
        check("rst_cmd_ready", 64'(cmd_ready), 64'(1));
        check("rst_rsp", 64'({rsp_valid, rsp_err, rsp_data}), 64'(0));
        check("rst_spi_ctl", 64'({spi_scom, spi_cpol, spi_cpha, spi_data_len}), 64'(0));
        check("rst_spi_cs", 64'(spi_cs), 64'(8'hFF));
        check("rst_spi_tx", 64'(spi_tx), 64'(0));
        check("rst_levels", 64'({cmd_level, rsp_level, txn_count}), 64'(0));

        // Single mode-0 byte
        push_cmd(2'd0, 2'd0, 8'hFE, 32'hA500_0000);
        wait_scom(n);
        check("scom_latency", 64'(n), 64'(2));
        check("single_cs", 64'(spi_cs), 64'(8'hFE));
        wait_drain();
        check("single_txn", 64'(txn_count), 64'(1));
        check("single_rsp_count", 64'(rsp_count), 64'(1));

        // Fill the response FIFO; a fifth command must not dispatch
        rsp_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            push_cmd(2'($urandom_range(0, 3)), 2'(i), 8'($urandom_range(1, 255)), 32'hDEAD_CE11);
        end
        n = 0;
        while (rsp_level != 5'd4 && n < 300) begin
            tick();
            n++;
        end
        check("full_rsp_level", 64'(rsp_level), 64'(4));
        base = scom_count;
        push_cmd(2'd1, 2'd3, 8'h7F, 32'h1234_5678);
        repeat (40) tick();
        check("no_fifth_dispatch", 64'(scom_count - base), 64'(0));
        check("stall_cmd_level", 64'(cmd_level), 64'(1));
        check("stall_rsp_level", 64'(rsp_level), 64'(4));
        check("stall_txn", 64'(txn_count), 64'(5));
        rsp_ready = 1'b1;
        wait_drain();
        check("txn_after_fill", 64'(txn_count), 64'(accepted));

        // Mode 3
        push_cmd(2'd3, 2'd1, 8'hBF, 32'hC3A5_0000);
        wait_scom(n);
        check("mode3_cpol_cpha", 64'({spi_cpol, spi_cpha}), 64'(2'b11));
        wait_drain();

        // Device never answers: timeout path, then a normal command
        rsp_ready = 1'b0;
        push_cmd(2'd0, 2'd2, 8'h00, 32'h1122_3344);
        wait_scom(n);
        n = 0;
        while (!rsp_valid && n < 60) begin
            tick();
            n++;
        end
        check("timeout_latency", 64'(n), 64'(Timeout + 2));
        check("timeout_err", 64'(rsp_err), 64'(1));
        check("timeout_data", 64'(rsp_data), 64'(0));
        rsp_ready = 1'b1;
        push_cmd(2'd2, 2'd3, 8'hFD, 32'h0BAD_F00D);
        wait_drain();
        check("txn_after_timeout", 64'(txn_count), 64'(accepted));

        // Reset during WAIT_DONE with two commands queued
        hold_long = 1'b1;
        for (int i = 0; i < 3; i++) begin
            push_cmd(2'd0, 2'd3, 8'hEF, $urandom);
        end
        n = 0;
        while (!spi_busy && n < 60) begin
            tick();
            n++;
        end
        if (!spi_busy) fail("busy_timeout");
        tick();
        tick();
        check("queued_before_rst", 64'(cmd_level), 64'(2));
        rcount = rsp_count;
        do_reset();
        hold_long = 1'b0;
        check("midrst_levels", 64'({cmd_level, rsp_level}), 64'(0));
        check("midrst_cs", 64'(spi_cs), 64'(8'hFF));
        check("midrst_txn", 64'(txn_count), 64'(0));
        repeat (40) tick();
        check("midrst_no_rsp", 64'({rsp_valid, rsp_level}), 64'(0));
        check("midrst_no_pop", 64'(rsp_count - rcount), 64'(0));

        // Both FIFOs full, then release at the boundary
        rsp_ready = 1'b0;
        for (int i = 0; i < 8; i++) begin
            push_cmd(2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)),
                     8'($urandom_range(1, 255)), $urandom);
        end
        n = 0;
        while ((cmd_level != 5'd4 || rsp_level != 5'd4) && n < 300) begin
            tick();
            n++;
        end
        cmd_mode  = 2'd1;
        cmd_len   = 2'd2;
        cmd_cs    = 8'h5A;
        cmd_data  = 32'hCAFE_BABE;
        cmd_valid = 1'b1;
        for (int i = 0; i < 20; i++) begin
            tick();
            check("full_hold", 64'({cmd_ready, cmd_level, rsp_level}), 64'({1'b0, 5'd4, 5'd4}));
        end
        rsp_ready = 1'b1;
        n = 0;
        while (!cmd_ready && n < 200) begin
            tick();
            n++;
        end
        tick();
        cmd_valid = 1'b0;
        wait_drain();
        check("txn_after_full", 64'(txn_count), 64'(accepted));

        // Randomized traffic
        for (int i = 0; i < 600; i++) begin
            cmd_valid = 1'($urandom_range(0, 1));
            cmd_mode  = 2'($urandom_range(0, 3));
            cmd_len   = 2'($urandom_range(0, 3));
            cmd_cs    = ($urandom_range(0, 7) == 0) ? 8'h00 : 8'($urandom_range(1, 255));
            cmd_data  = $urandom;
            rsp_ready = ($urandom_range(0, 9) < 7);
            tick();
        end
        cmd_valid = 1'b0;
        rsp_ready = 1'b1;
        wait_drain();
        check("txn_total", 64'(txn_count), 64'(16'(accepted)));
        check("final_levels", 64'({cmd_level, rsp_level}), 64'(0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/spi_cmd_queue.md
SPI_CMD_QUEUE -- requirements
Module: spi_cmd_queue

Interface
REQ-001 SHALL have one clock; reset is synchronous and active-high.
REQ-002 SHALL have parameter DEPTH, default 4, meaning command and response FIFO depth (power of 2, 2..16).
REQ-003 SHALL have parameter BUSY_TIMEOUT, default 7, meaning max cycles after spi_scom before spi_busy must assert.
REQ-004 SHALL have the following ports, with clk and rst listed first:
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- cmd_valid  in  1  command offered
- cmd_ready  out  1  command FIFO not full
- cmd_mode  in  2  {CPOL,CPHA}
- cmd_len  in  2  byte count minus 1
- cmd_cs  in  8  chip-select pattern
- cmd_data  in  32  tx bytes, first byte in [31:24]
- rsp_valid  out  1  response FIFO not empty
- rsp_ready  in  1  consumer accepts response
- rsp_data  out  32  rx bytes, right-aligned, last byte in [7:0]
- rsp_err  out  1  transaction aborted by timeout
- spi_scom  out  1  start pulse to SPI controller
- spi_cpol  out  1  CPOL to SPI controller
- spi_cpha  out  1  CPHA to SPI controller
- spi_data_len  out  2  DATA_LEN to SPI controller
- spi_cs  out  8  CS_i to SPI controller
- spi_tx  out  32  TxBuffer to SPI controller
- spi_busy  in  1  BUSY from SPI controller
- spi_rx  in  32  RxBuffer from SPI controller
- cmd_level  out  5  command FIFO occupancy
- rsp_level  out  5  response FIFO occupancy
- txn_count  out  16  completed transactions

Function
REQ-005 SHALL accept a command on a cycle where cmd_valid && cmd_ready; cmd_ready SHALL be 0 when cmd_level == DEPTH.
REQ-006 SHALL pop a response on a cycle where rsp_valid && rsp_ready; rsp_data and rsp_err SHALL show the FIFO head combinationally.
REQ-007 SHALL support a simultaneous push and pop on either FIFO, leaving the level unchanged; pointers SHALL wrap modulo DEPTH.
REQ-008 SHALL implement the following FSM, with each state transition taking one cycle:
- IDLE: if the command FIFO is non-empty and (rsp_level + inflight) < DEPTH, go to SETUP.
- SETUP: pop the head command into output registers and drive spi_cpol/spi_cpha/spi_data_len/spi_cs/spi_tx; spi_scom stays 0.
- LAUNCH: spi_scom = 1 for exactly one cycle.
- WAIT_BUSY: on spi_busy == 1, go to WAIT_DONE; after BUSY_TIMEOUT cycles without spi_busy, go to CAPTURE with the error flag set.
- WAIT_DONE: on spi_busy == 0, go to CAPTURE.
- CAPTURE: push the response, increment txn_count, return to IDLE.
REQ-009 SHALL hold spi_cpol/spi_cpha/spi_data_len/spi_cs/spi_tx stable from SETUP until the next SETUP, so that the mode settles at least one cycle before spi_scom.
REQ-010 SHALL never dispatch a command unless a response slot is guaranteed; responses SHALL never be dropped.
REQ-011 SHALL form rsp_data in CAPTURE as spi_rx masked to the low 8*(len+1) bits, with the upper bits zero; rsp_err SHALL be 0.
REQ-012 SHALL, on a timeout, push rsp_data = 0 and rsp_err = 1, and increment txn_count.
REQ-013 SHALL let txn_count wrap from 0xFFFF to 0x0000.
REQ-014 SHALL deliver responses in command order.
REQ-015 SHALL accept cmd pushes during any FSM state; the minimum dispatch latency from push to spi_scom is 3 cycles (push, IDLE->SETUP, LAUNCH).

Reset
REQ-016 SHALL, on rst == 1 at a clk edge, produce the following state:
- FSM in IDLE; both FIFOs empty.
- cmd_ready = 1, rsp_valid = 0, rsp_data = 0, rsp_err = 0.
- spi_scom = 0, spi_cpol = 0, spi_cpha = 0, spi_data_len = 0, spi_cs = 8'hFF, spi_tx = 0.
- cmd_level = 0, rsp_level = 0, txn_count = 0.
REQ-017 SHALL, when reset is asserted mid-transaction, abandon the transaction without pushing a response; spi_scom SHALL be 0 from the reset cycle on.

Verification
REQ-018 Single command, mode 0, len 0, data 0xA5000000, cs 0xFE, with a loopback SPI model -> spi_scom pulses 3 cycles after the push, spi_cs = 0xFE; rsp_data = 0x000000A5, rsp_err = 0, txn_count = 1.
REQ-019 Push 4 commands, len 0..3, data 0xDEADCE11, rsp_ready = 0 -> four SPI transactions complete; rsp_level = 4, and no fifth dispatch after pushing a 5th command; then pop -> the 4-byte response is 0xDEADCE11 and responses arrive in order.
REQ-020 Mode 3 command -> spi_cpol = spi_cpha = 1 at least one cycle before spi_scom, held through the fall of spi_busy.
REQ-021 SPI model that never asserts busy -> after BUSY_TIMEOUT = 7 cycles, rsp_err = 1, rsp_data = 0, FSM returns to IDLE, and the next command proceeds normally.
REQ-022 Reset asserted while in WAIT_DONE with 2 commands queued -> all levels 0, spi_cs = 0xFF, no response produced.
REQ-023 Simultaneous push and pop with full FIFOs over 20 cycles -> levels stay constant, and cmd_ready toggles correctly at the full boundary.
